// File: rtl/fdivs_if.sv
// Start/busy/done handshake bundle for the single-precision divider.
interface fdivs_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  flags;

    modport master (output start, a, b, input busy, done, result, flags);
    modport slave  (input start, a, b, output busy, done, result, flags);
endinterface

// File: rtl/fdivs.sv
// Multi-cycle IEEE-754 single divider: radix-2 restoring, RNE, denormals flushed.
module fdivs (
    input logic    clk,
    input logic    rst_n,
    fdivs_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DIV   = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [25:0] rem;
    logic [23:0] mb;
    logic [25:0] q;
    logic [9:0]  e;
    logic        sign;
    logic [31:0] result;
    logic [4:0]  flags;

    assign bus.busy   = (state == DIV) || (state == ROUND);
    assign bus.done   = (state == DONE);
    assign bus.result = result;
    assign bus.flags  = flags;

    // Operand classification; exp==0 covers both zero and flushed denormals.
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn_in;
    logic        special;
    logic [31:0] spec_res;
    logic [4:0]  spec_flags;
    logic [23:0] ma_in, mb_in;
    logic        ma_lt;
    logic [9:0]  e_in;

    always_comb begin
        ea     = bus.a[30:23];
        eb     = bus.b[30:23];
        fa     = bus.a[22:0];
        fb     = bus.b[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        sgn_in = bus.a[31] ^ bus.b[31];
        ma_in  = {1'b1, fa};
        mb_in  = {1'b1, fb};
        ma_lt  = ma_in < mb_in;
        e_in   = {2'b00, ea} - {2'b00, eb} + 10'd127 - {9'd0, ma_lt};

        special    = 1'b1;
        spec_res   = 32'd0;
        spec_flags = 5'b00000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res   = 32'h7FC00000;
            spec_flags = 5'b10000;
        end else if (a_inf) begin
            spec_res = {sgn_in, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_res   = {sgn_in, 8'hFF, 23'd0};
            spec_flags = 5'b01000;
        end else if (a_zero || b_inf) begin
            spec_res = {sgn_in, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    // One restoring step: subtract if it fits, then shift the partial remainder.
    logic        ge;
    logic [25:0] rem_nx;
    always_comb begin
        ge     = rem >= {2'b00, mb};
        rem_nx = ge ? (rem - {2'b00, mb}) : rem;
    end

    // Round to nearest even on {G, R|S}; a carry out renormalises by one.
    logic        g, r, s, nx, rnd_up;
    logic [24:0] rnd;
    logic [23:0] mant;
    logic [9:0]  e_rnd;
    logic [31:0] rnd_res;
    logic [4:0]  rnd_flags;
    always_comb begin
        g      = q[1];
        r      = q[0];
        s      = |rem;
        nx     = g | r | s;
        rnd_up = g & (r | s | q[2]);
        rnd    = {1'b0, q[25:2]} + {24'd0, rnd_up};
        mant   = rnd[24] ? rnd[24:1] : rnd[23:0];
        e_rnd  = e + {9'd0, rnd[24]};
        if ($signed(e_rnd) >= 10'sd255) begin
            rnd_res   = {sign, 8'hFF, 23'd0};
            rnd_flags = 5'b00101;
        end else if ($signed(e_rnd) <= 10'sd0) begin
            rnd_res   = {sign, 31'd0};
            rnd_flags = 5'b00011;
        end else begin
            rnd_res   = {sign, e_rnd[7:0], mant[22:0]};
            rnd_flags = {4'b0000, nx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            rem    <= 26'd0;
            mb     <= 24'd0;
            q      <= 26'd0;
            e      <= 10'd0;
            sign   <= 1'b0;
            result <= 32'd0;
            flags  <= 5'd0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    sign <= sgn_in;
                    if (special) begin
                        result <= spec_res;
                        flags  <= spec_flags;
                        state  <= DONE;
                    end else begin
                        rem   <= ma_lt ? {1'b0, ma_in, 1'b0} : {2'b00, ma_in};
                        mb    <= mb_in;
                        e     <= e_in;
                        q     <= 26'd0;
                        cnt   <= 5'd0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem <= {rem_nx[24:0], 1'b0};
                    q   <= {q[24:0], ge};
                    if (cnt == 5'd25) begin
                        cnt   <= 5'd0;
                        state <= ROUND;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ROUND: begin
                    result <= rnd_res;
                    flags  <= rnd_flags;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fdivs.sv
// Directed-vector bench for fdivs: latency, busy/done, result and flags.
module tb_fdivs;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fdivs_if bus ();
    fdivs u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to done; optionally poke a second start at edge 5.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [4:0] exp_flags,
                          input int exp_lat, input bit poke);
        int n, busy_cnt, overlap;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 32'hDEADBEEF;
        bus.b     = 32'h12345678;
        n = 0; busy_cnt = 0; overlap = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_cnt++;
            if (poke && n == 4) begin
                bus.start = 1'b1;
                bus.a     = 32'h40C00000;
                bus.b     = 32'h40000000;
            end
            if (poke && n == 5) bus.start = 1'b0;
            @(posedge clk);
            #1;
            n++;
            if (bus.busy && bus.done) overlap++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        chk({tag, "_overlap"}, overlap, 0);
        chk({tag, "_result"}, bus.result, exp_res);
        chk({tag, "_flags"}, {27'd0, bus.flags}, {27'd0, exp_flags});
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_held"}, bus.result, exp_res);
    endtask

    initial begin
        int n, seen;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        #1;
        chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("rst_done",   {31'd0, bus.done}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_flags",  {27'd0, bus.flags}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27, 1'b0);
        run_op("one_third",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 27, 1'b1);
        run_op("neg_div0",   32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000, 0, 1'b0);
        run_op("zero_zero",  32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 0, 1'b0);
        run_op("overflow",   32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 27, 1'b0);
        run_op("underflow",  32'h00800000, 32'h7F000000, 32'h00000000, 5'b00011, 27, 1'b0);
        run_op("inf_by_x",   32'h7F800000, 32'hC0000000, 32'hFF800000, 5'b00000, 0, 1'b0);
        run_op("x_by_inf",   32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00000, 0, 1'b0);
        run_op("round_even", 32'h3FC00000, 32'h3F800000, 32'h3FC00000, 5'b00000, 27, 1'b0);

        // Reset mid-DIV: outputs clear immediately and the aborted op never completes.
        run_op("pre_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h3FC00000;
        bus.b     = 32'h3F800000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done",   {31'd0, bus.done}, 32'd0);
        chk("mid_rst_result", bus.result, 32'd0);
        chk("mid_rst_flags",  {27'd0, bus.flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        chk("no_done_after_rst", seen, 0);
        run_op("reissue", 32'h3FC00000, 32'h3F800000, 32'h3FC00000, 5'b00000, 27, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fdivs.md
# fdivs

Multi-cycle IEEE-754 single-precision divider. Produces the `FPU_DIV` single-precision operand (`divs_out`) consumed by the FPU result mux. Uses a start/busy/done handshake so the non-pipelined core can stall on FDIV. Radix-2 restoring mantissa division; round-to-nearest-even; denormals flushed to zero.

## Interface
- none: fixed single precision, fixed iteration count of 26.

- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  accept `a`/`b`; honoured only when `busy`=0.
- `a`  in  32  dividend, IEEE-754 single.
- `b`  in  32  divisor, IEEE-754 single.
- `busy`  out  1  high from the accepting edge until the edge that raises `done`.
- `done`  out  1  one-cycle pulse; `result`/`flags` valid from this cycle on.
- `result`  out  32  quotient; held until the next accepted `start`.
- `flags`  out  5  {invalid, div_by_zero, overflow, underflow, inexact}; held with `result`.

## Operation
- States: IDLE, DIV, ROUND, DONE.
- IDLE + `start`: register `a`/`b`, classify, then branch.
  - Special case: go to DONE with `result`/`flags` loaded.
  - Otherwise: go to DIV.
- Denormal inputs (exp=0, frac≠0) are treated as signed zero. Sign is always `a[31]^b[31]`, except NaN.
- Special-case priority:
  - Either input NaN, 0/0, or inf/inf: 0x7FC00000, invalid.
  - inf/x: signed inf, flags 0.
  - x/0 (x finite nonzero): signed inf, div_by_zero.
  - 0/x or x/inf: signed zero, flags 0.
- Unpack: ma={1,frac_a}, mb={1,frac_b} (24 bits). e = ea − eb + 127, 10-bit signed.
  - If ma<mb: ma<<=1 and e−=1, so the quotient lies in [1,2).
- DIV: one quotient bit per cycle, 26 cycles (counter 0..25).
  - Each cycle: rem=rem−mb if rem≥mb (q bit 1), then rem<<=1.
  - Yields 24 mantissa bits, guard, round. Sticky = (final rem≠0).
- ROUND: RNE on {G, R|S}.
  - Mantissa carry-out (0x1000000): shift right 1, e+=1.
  - e≥255: signed inf, overflow+inexact.
  - e≤0: signed zero, underflow+inexact.
  - Else normal pack; inexact = G|R|S.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` while `busy`=1 is ignored. Operand changes after the accepting edge are ignored.
- `start` high in the DONE cycle is ignored; it is accepted on the next cycle (IDLE).

## Timing
- Reset (async, `rst_n`=0): state=IDLE, `busy`=0, `done`=0, `result`=0, `flags`=0, counter=0. Takes effect immediately, including mid-DIV.
  - The in-flight operation is discarded; no `done` is produced for it.
  - Release is synchronous to the next rising edge.
- Let edge 0 be the edge that samples `start`.
- Normal operands:
  - Edge 0: →DIV, `busy`=1.
  - Edges 1–26: iterations.
  - Edge 26: →ROUND.
  - Edge 27: →DONE; `result`/`flags` updated, `done`=1, `busy`=0.
  - Edge 28: `done`=0.
  - Latency: 27 cycles; initiation interval: 28 cycles.
- Special operands: edge 0 →DONE; `result`/`flags` updated, `done`=1, `busy` stays 0. Edge 1: `done`=0.
- `result`/`flags` change only on the edge that raises `done` (or on reset).
- `done` and `busy` are never high together.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0): `busy` for edges 0–27, `done` after edge 27, `result`=0x40400000, `flags`=0.
- 0x3F800000 / 0x40400000 (1/3): `result`=0x3EAAAAAB, `flags`=00001. A second `start` asserted at edge 5 with new operands is ignored; `result` stays 0x3EAAAAAB.
- 0xBF800000 / 0x00000000: `done` after edge 0, `result`=0xFF800000, `flags`=01000. Then 0x00000000 / 0x00000000: `result`=0x7FC00000, `flags`=10000.
- 0x7F000000 / 0x3E800000 (2^127/0.25): `result`=0x7F800000, `flags`=00101. Then 0x00800000 / 0x7F000000: `result`=0x00000000, `flags`=00011.
- 0x3FC00000 / 0x3F800000 with `rst_n` pulsed low between edges 10 and 11: `busy`/`done`/`result`/`flags` go to 0 immediately, and no `done` follows. Re-issue after release: `result`=0x3FC00000, `done` after edge 27.
